// File: rtl/add_mop_stream_pkg.sv
// Shared definitions for the streaming multi-operand adder.
//   state_e   : phases of one stream (accumulate, resolve, present result)
//   cnt_width : width of the operand counter for a given max_ops
package add_mop_stream_pkg;

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FINAL = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Bits needed to count 0..max_ops inclusive.
  function automatic int cnt_width(input int max_ops);
    return $clog2(max_ops + 32'sd1);
  endfunction

endpackage

// File: rtl/Add.sv
// Combinational two-operand adder, sum mod 2^width, built as a prefix network.
//   a_i, b_i : addends
//   sum_o    : a_i + b_i mod 2^width
//   speed    : 0 ripple chain, 1 Brent-Kung, 2 Sklansky (other values fall back to ripple)
// Every architecture is expressed as a list of stages; in each stage a bit either
// merges its (g,p) group with a lower, already-formed group or passes through.
module Add #(
  parameter int width = 8,
  parameter int speed = 2
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic [width-1:0] sum_o
);

  localparam int Lvls = $clog2(width);
  localparam int NStg = (speed == 32'sd1) ? (32'sd2 * Lvls) :
                        (speed == 32'sd2) ? Lvls : (width - 32'sd1);

  // Does bit i combine with a lower group in stage s?
  function automatic bit stage_act(input int s, input int i);
    int span;
    bit hit;
    span = 32'sd0;
    hit  = 1'b0;
    case (speed)
      32'sd1: begin
        if (s < Lvls) begin
          // Up-sweep: build power-of-two aligned groups.
          span = 32'sd1 << s;
          hit  = ((i + 32'sd1) % (32'sd2 * span)) == 32'sd0;
        end else begin
          // Down-sweep: fill in the remaining prefixes from complete ones.
          span = 32'sd1 << (32'sd2 * Lvls - 32'sd1 - s);
          hit  = (((i + 32'sd1) % (32'sd2 * span)) == span) && (i >= 32'sd2 * span);
        end
      end
      32'sd2: hit = ((i >> s) & 32'sd1) != 32'sd0;
      default: hit = (i == s + 32'sd1);
    endcase
    return hit;
  endfunction

  // Index of the lower group bit i merges with in stage s.
  function automatic int stage_src(input int s, input int i);
    int src;
    case (speed)
      32'sd1: begin
        if (s < Lvls) begin
          src = i - (32'sd1 << s);
        end else begin
          src = i - (32'sd1 << (32'sd2 * Lvls - 32'sd1 - s));
        end
      end
      32'sd2: src = ((i >> s) << s) - 32'sd1;
      default: src = i - 32'sd1;
    endcase
    return src;
  endfunction

  logic [width-1:0] g_s;
  logic [width-1:0] p_s;
  logic [width-1:0] gpre_s;
  logic [width-1:0] p_prefix_unused;

  assign g_s = a_i & b_i;
  assign p_s = a_i ^ b_i;

  for (genvar s = 0; s < NStg; s++) begin : g_stg
    logic [width-1:0] gi;
    logic [width-1:0] pi;
    logic [width-1:0] go;
    logic [width-1:0] po;

    if (s == 0) begin : g_first
      assign gi = g_s;
      assign pi = p_s;
    end else begin : g_next
      assign gi = g_stg[s-1].go;
      assign pi = g_stg[s-1].po;
    end

    for (genvar i = 0; i < width; i++) begin : g_bit
      if (stage_act(s, i)) begin : g_op
        localparam int J = stage_src(s, i);
        assign go[i] = gi[i] | (pi[i] & gi[J]);
        assign po[i] = pi[i] & pi[J];
      end else begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end
  end

  // After the last stage go[i] is the carry out of bit i. The group propagate
  // of the full prefix plays no part in the sum.
  assign gpre_s          = g_stg[NStg-1].go;
  assign p_prefix_unused = g_stg[NStg-1].po;

  // Carry into bit i is the carry out of bit i-1; the top carry drops off.
  assign sum_o = p_s ^ (gpre_s << 1'b1);

endmodule

// File: rtl/csa_3to2.sv
// One carry-save (3:2) compression step over width-bit vectors.
//   a_i, b_i, c_i : the three addends
//   sum_o         : bitwise sum (a ^ b ^ c)
//   carry_o       : bitwise majority, NOT shifted; bit k weighs 2^(k+1)
module csa_3to2 #(
  parameter int width = 8
) (
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  input  logic [width-1:0] c_i,
  output logic [width-1:0] sum_o,
  output logic [width-1:0] carry_o
);

  assign sum_o   = a_i ^ b_i ^ c_i;
  assign carry_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/add_mop_stream.sv
// Streaming multi-operand adder: S = sum of all operands of a stream mod 2^width.
//   clk_i, rst_ni            : clock, synchronous active-low reset
//   op_i/op_valid_i/op_last_i/op_ready_o : operand stream, one operand per beat
//   sum_o/cnt_o/sum_valid_o/sum_ready_i  : resolved sum and (saturating) operand count
// Operands are folded into a carry-save pair (s_q, c_q); only the final beat
// pays for a carry-propagate addition, which is registered into sum_o.
module add_mop_stream
  import add_mop_stream_pkg::*;
#(
  parameter  int width   = 8,
  parameter  int max_ops = 255,
  parameter  int speed   = 2,
  localparam int CntW    = cnt_width(max_ops)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [width-1:0]  op_i,
  input  logic              op_valid_i,
  input  logic              op_last_i,
  output logic              op_ready_o,
  output logic [width-1:0]  sum_o,
  output logic [CntW-1:0]   cnt_o,
  output logic              sum_valid_o,
  input  logic              sum_ready_i
);

  state_e            state_q, state_d;
  logic [width-1:0]  s_q, s_d;
  logic [width-1:0]  c_q, c_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [width-1:0]  sum_q, sum_d;
  logic [CntW-1:0]   cnt_out_q, cnt_out_d;
  logic              valid_q, valid_d;

  logic              beat_s;
  logic [width-1:0]  csa_sum_s;
  logic [width-1:0]  csa_carry_s;
  logic [width-1:0]  add_sum_s;

  assign op_ready_o  = (state_q == ACC);
  assign beat_s      = op_valid_i & op_ready_o;
  assign sum_o       = sum_q;
  assign cnt_o       = cnt_out_q;
  assign sum_valid_o = valid_q;

  csa_3to2 #(
    .width (width)
  ) u_csa (
    .a_i     (s_q),
    .b_i     (c_q),
    .c_i     (op_i),
    .sum_o   (csa_sum_s),
    .carry_o (csa_carry_s)
  );

  Add #(
    .width (width),
    .speed (speed)
  ) u_add (
    .a_i   (s_q),
    .b_i   (c_q),
    .sum_o (add_sum_s)
  );

  // Next-state, accumulator and result-register updates for the stream FSM.
  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cnt_out_d = cnt_out_q;
    valid_d   = valid_q;
    case (state_q)
      ACC: begin
        if (beat_s) begin
          s_d = csa_sum_s;
          // Carry weighs one place higher; its MSB falls off (mod 2^width).
          c_d = csa_carry_s << 1'b1;
          if (cnt_q != {CntW{1'b1}}) begin
            cnt_d = cnt_q + CntW'(1'b1);
          end else begin
            cnt_d = cnt_q;
          end
          if (op_last_i) begin
            state_d = FINAL;
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end
      FINAL: begin
        sum_d     = add_sum_s;
        cnt_out_d = cnt_q;
        valid_d   = 1'b1;
        state_d   = OUT;
      end
      OUT: begin
        if (sum_ready_i) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = ACC;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        s_d     = '0;
        c_d     = '0;
        cnt_d   = '0;
        valid_d = 1'b0;
        state_d = ACC;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ACC;
      s_q       <= '0;
      c_q       <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      cnt_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      c_q       <= c_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      cnt_out_q <= cnt_out_d;
      valid_q   <= valid_d;
    end
  end

endmodule
